// File: rtl/countdown_ctrl_if.sv
// Handshake and counter-control bundle between the character source / down-counter
// (master side) and the countdown controller (slave side).
interface countdown_ctrl_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [15:0] ascii_out;
    logic        load;
    logic        decrement;
    logic        cnt_done;
    logic        busy;
    logic        finished;
    logic        error;

    modport master (
        output char_in, char_valid, cnt_done,
        input  char_ready, ascii_out, load, decrement, busy, finished, error
    );

    modport slave (
        input  char_in, char_valid, cnt_done,
        output char_ready, ascii_out, load, decrement, busy, finished, error
    );
endinterface

// File: rtl/countdown_ctrl.sv
// Front-end controller for the two-digit ASCII down-counter: assembles a two-digit
// preset from an ASCII byte stream, loads the counter, paces decrement pulses and
// reports completion once the counter's done flag is seen after at least one tick.
module countdown_ctrl #(
    parameter int TICK_CYCLES = 100
) (
    input  logic             clock,
    input  logic             reset,
    countdown_ctrl_if.slave  bus
);
    localparam int TW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    // Decrement is registered, so it is raised one count early to land on TICK_LAST.
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_CYCLES - 2);
    localparam logic [7:0]  CH_ZERO  = 8'h30;
    localparam logic [7:0]  CH_CLEAR = 8'h43;
    localparam logic [15:0] PAIR_ZERO = 16'h3030;

    typedef enum logic [2:0] {IDLE, DIGIT1, LOAD, RUN, FINISH} state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic          check;
    logic          accept;
    logic          is_digit;
    logic          is_clear;

    // The only cycle the controller refuses characters is the load cycle.
    assign bus.char_ready = (state != LOAD);
    assign accept   = bus.char_valid & bus.char_ready;
    assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
    assign is_clear = (bus.char_in == CH_CLEAR);

    // Control FSM with all outputs registered; pulses default low every cycle and an
    // error is not re-raised on the cycle right after one, keeping every pulse single-cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bus.ascii_out <= PAIR_ZERO;
            bus.load      <= 1'b0;
            bus.decrement <= 1'b0;
            bus.error     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.finished  <= 1'b0;
            tick          <= '0;
            check         <= 1'b0;
        end else begin
            bus.load      <= 1'b0;
            bus.decrement <= 1'b0;
            bus.error     <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    if (accept) begin
                        bus.finished <= 1'b0;
                        if (is_digit) begin
                            bus.ascii_out[15:8] <= bus.char_in;
                            state <= DIGIT1;
                        end else begin
                            bus.error <= ~bus.error;
                            state <= IDLE;
                        end
                    end
                end
                DIGIT1: begin
                    if (accept) begin
                        if (is_digit && !(bus.ascii_out[15:8] == CH_ZERO && bus.char_in == CH_ZERO)) begin
                            bus.ascii_out[7:0] <= bus.char_in;
                            bus.load <= 1'b1;
                            bus.busy <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            // Non-digit or a "00" preset: nothing to count, start over.
                            bus.error     <= ~bus.error;
                            bus.ascii_out <= PAIR_ZERO;
                            state         <= IDLE;
                        end
                    end
                end
                LOAD: begin
                    tick  <= '0;
                    check <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    if (accept && is_clear) begin
                        // Abort beats both a due decrement and a done check.
                        bus.ascii_out <= PAIR_ZERO;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else if (check && bus.cnt_done) begin
                        bus.busy     <= 1'b0;
                        bus.finished <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
                        if (tick == TICK_PRE) bus.decrement <= 1'b1;
                        // done is only trusted once this run has ticked the counter,
                        // so a flag left over from the previous run is ignored.
                        if (bus.decrement) check <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed table, hand-written multi-cycle sequences and a
// random phase, all checked against a behavioural model plus a model of the counter.
module tb_countdown_ctrl;
    localparam int T = 4;

    logic clock = 1'b0;
    logic reset;
    countdown_ctrl_if bus();

    countdown_ctrl #(.TICK_CYCLES(T)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: decrements are due at fixed multiples of T after the load cycle.
    typedef enum int {M_IDLE, M_D1, M_LOAD, M_RUN, M_FIN} mode_t;
    mode_t       mode;
    byte unsigned m_tens, m_units;
    bit          e_load, e_dec, e_err, armed;
    longint      cyc = 0, load_cyc = 0;

    // Down-counter environment: integer value, sticky done, not affected by controller reset.
    int     cval = 0;
    bit     cdone = 0;
    longint done_cyc = 0;

    typedef struct {
        bit           v;
        byte unsigned ch;
        logic [15:0]  asc;
        bit           ld;
        bit           er;
        bit           bsy;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [21:0] dut_vec();
        return {bus.char_ready, bus.ascii_out, bus.load, bus.decrement, bus.busy, bus.finished, bus.error};
    endfunction

    function automatic logic [21:0] exp_vec();
        return {mode != M_LOAD, m_tens, m_units, e_load, e_dec,
                (mode == M_LOAD) || (mode == M_RUN), mode == M_FIN, e_err};
    endfunction

    task automatic model_reset();
        mode = M_IDLE; m_tens = 8'h30; m_units = 8'h30;
        e_load = 0; e_dec = 0; e_err = 0; armed = 0;
    endtask

    task automatic model_edge(input bit v, input byte unsigned c, input bit done);
        bit acc, dig, rej, nl, nd;
        longint nxt;
        acc = v && (mode != M_LOAD);
        dig = (c >= 8'h30) && (c <= 8'h39);
        rej = 0; nl = 0; nd = 0;
        nxt = cyc + 1;
        case (mode)
            M_IDLE, M_FIN: if (acc) begin
                if (dig) begin m_tens = c; mode = M_D1; end
                else begin rej = 1; mode = M_IDLE; end
            end
            M_D1: if (acc) begin
                if (dig && !(m_tens == 8'h30 && c == 8'h30)) begin
                    m_units = c; mode = M_LOAD; nl = 1; load_cyc = nxt;
                end else begin
                    rej = 1; m_tens = 8'h30; m_units = 8'h30; mode = M_IDLE;
                end
            end
            M_LOAD: begin mode = M_RUN; armed = 0; end
            M_RUN: begin
                if (acc && c == 8'h43) begin
                    mode = M_IDLE; m_tens = 8'h30; m_units = 8'h30;
                end else if (armed && done) begin
                    mode = M_FIN;
                end else begin
                    if (e_dec) armed = 1;
                    nd = ((nxt - load_cyc) % T) == 0;
                end
            end
            default: ;
        endcase
        e_err  = rej && !e_err;
        e_load = nl;
        e_dec  = nd;
        cyc    = nxt;
    endtask

    task automatic step(input bit v, input byte unsigned c);
        bit pl, pd;
        int pre;
        bus.char_valid = v;
        bus.char_in    = c;
        @(posedge clock);
        pl  = e_load;
        pd  = e_dec;
        pre = (int'(m_tens) - 48) * 10 + (int'(m_units) - 48);
        model_edge(v, c, cdone);
        if (pl) begin
            cval = pre; cdone = 0;
        end else if (pd && cval > 0) begin
            cval--;
            if (cval == 0 && !cdone) begin cdone = 1; done_cyc = cyc; end
        end
        #1;
        bus.cnt_done = cdone;
        chk("outputs", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    // Idle until finished, checking decrement spacing; budget expiry is a failure.
    task automatic run_to_finish(input string tag, input int budget, output int ndec);
        longint last;
        last = -1;
        ndec = 0;
        for (int i = 0; i < budget && !bus.finished; i++) begin
            step(0, 8'h00);
            if (bus.decrement) begin
                ndec++;
                if (last >= 0) chk({tag, "_dec_gap"}, 32'(cyc - last), T);
                last = cyc;
            end
        end
        chk({tag, "_finished"}, 32'(bus.finished), 1);
    endtask

    initial begin
        int ndec;
        bus.char_valid = 0; bus.char_in = 0; bus.cnt_done = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        chk("reset_outputs", 32'(dut_vec()), 32'({1'b1, 16'h3030, 5'b0}));
        reset = 0;

        // Preset "42", abort, "00" rejection, "7A" rejection, IDLE rejection, back-to-back rejects.
        tbl[0]  = '{1'b1, 8'h34, 16'h3430, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h32, 16'h3432, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, 16'h3432, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 8'h43, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h30, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h30, 16'h3030, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 8'h37, 16'h3730, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h41, 16'h3030, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h41, 16'h3030, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h42, 16'h3030, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 8'h42, 16'h3030, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].v, tbl[i].ch);
            chk("tbl_ascii", 32'(bus.ascii_out), 32'(tbl[i].asc));
            chk("tbl_flags", 32'({bus.load, bus.error, bus.busy}), 32'({tbl[i].ld, tbl[i].er, tbl[i].bsy}));
        end
        step(0, 8'h00);

        // "03" runs to completion: 3 ticks, finished one cycle after counter done, no 4th tick.
        step(1, 8'h30); step(1, 8'h33);
        chk("t2_load", 32'({bus.load, bus.busy}), 32'(2'b11));
        run_to_finish("t2", 200, ndec);
        chk("t2_decs", 32'(ndec), 3);
        chk("t2_fin_lag", 32'(cyc - done_cyc), 1);
        ndec = 0;
        for (int i = 0; i < 3 * T; i++) begin step(0, 8'h00); ndec += int'(bus.decrement); end
        chk("t2_no_more_dec", 32'(ndec), 0);

        // "01" to finish, then "05" while the counter's done flag is still set.
        step(1, 8'h30); step(1, 8'h31);
        run_to_finish("t5a", 100, ndec);
        chk("t5a_decs", 32'(ndec), 1);
        chk("t5_stale_done", 32'(bus.cnt_done), 1);
        step(1, 8'h30); step(1, 8'h35);
        run_to_finish("t5b", 200, ndec);
        chk("t5b_decs", 32'(ndec), 5);

        // "C" on the edge a decrement is due: abort, no decrement.
        step(1, 8'h30); step(1, 8'h39);
        for (int i = 0; i < T - 1; i++) step(0, 8'h00);
        step(1, 8'h43);
        chk("t6_abort", 32'({bus.decrement, bus.busy, bus.ascii_out}), 32'({2'b00, 16'h3030}));

        // Asynchronous reset in the middle of a run.
        step(1, 8'h31); step(1, 8'h32);
        for (int i = 0; i < T + 2; i++) step(0, 8'h00);
        reset = 1;
        #2;
        chk("t6_reset_mid_run", 32'(dut_vec()), 32'({1'b1, 16'h3030, 5'b0}));
        #2;
        reset = 0;
        model_reset();

        // Random phase against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            byte unsigned c;
            r = int'($urandom_range(0, 99));
            if (r < 60)      c = 8'(8'h30 + $urandom_range(0, 9));
            else if (r < 64) c = 8'h43;
            else             c = 8'($urandom_range(0, 255));
            step($urandom_range(0, 2) == 0, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
